frame_buffer_arbiter: RTL

Shares the single-port 24-bit pixel frame buffer BRAM (196,608 entries) between three requesters: the UART pixel loader (writes), the display pixel fetch (reads), and the UART readback path (reads). Display reads get fixed priority. Loader and readback share the remaining slots round-robin, with a starvation override so neither is locked out by a continuous display stream. The block sits between the requesters and the BRAM and owns every BRAM control signal.

---
 rtl/frame_buffer_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_buffer_arbiter.sv
// Arbiter for the single-port pixel frame buffer BRAM: display reads have fixed priority,
// loader writes and readback reads share the remaining slots round-robin with starvation override.
module frame_buffer_arbiter #(
    parameter int DEPTH      = 196608,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic              tx_rvalid,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [1:0]        owner,
    output logic              err_addr
);

    localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_WR   = 2'd1,
        OWN_DISP = 2'd2,
        OWN_TX   = 2'd3
    } owner_e;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    owner_e            win_s;
    owner_e            tag_dest_q, tag_dest_d;
    logic              wr_starved_s, tx_starved_s;
    logic              granted_s, range_ok_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_din_s;

    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              err_q, err_d;
    logic              tag_vld_q, tag_vld_d;
    logic              tag_ok_q, tag_ok_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic              tx_rvalid_q, tx_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic [DATA_W-1:0] tx_rdata_q, tx_rdata_d;

    // Winner selection: starvation override, then display, then round-robin pointer (0 = wr).
    always_comb begin
        win_s        = OWN_NONE;
        wr_starved_s = wr_req && (wr_cnt_q == CNT_MAX);
        tx_starved_s = tx_req && (tx_cnt_q == CNT_MAX);
        if (rst) begin
            win_s = OWN_NONE;
        end else if (wr_starved_s && tx_starved_s) begin
            win_s = ptr_q ? OWN_TX : OWN_WR;
        end else if (wr_starved_s) begin
            win_s = OWN_WR;
        end else if (tx_starved_s) begin
            win_s = OWN_TX;
        end else if (disp_req) begin
            win_s = OWN_DISP;
        end else if (wr_req && tx_req) begin
            win_s = ptr_q ? OWN_TX : OWN_WR;
        end else if (wr_req) begin
            win_s = OWN_WR;
        end else if (tx_req) begin
            win_s = OWN_TX;
        end else begin
            win_s = OWN_NONE;
        end
    end

    // BRAM port mux; address and write data hold their last values when idle.
    always_comb begin
        sel_addr_s = mem_addr_q;
        sel_din_s  = mem_din_q;
        case (win_s)
            OWN_WR: begin
                sel_addr_s = wr_addr;
                sel_din_s  = wr_data;
            end
            OWN_DISP: sel_addr_s = disp_addr;
            OWN_TX:   sel_addr_s = tx_addr;
            default: begin
                sel_addr_s = mem_addr_q;
                sel_din_s  = mem_din_q;
            end
        endcase
        granted_s  = (win_s != OWN_NONE);
        range_ok_s = addr_in_range(sel_addr_s);
    end

    assign wr_gnt      = (win_s == OWN_WR);
    assign disp_gnt    = (win_s == OWN_DISP);
    assign tx_gnt      = (win_s == OWN_TX);
    assign owner       = win_s;
    assign mem_en      = granted_s && range_ok_s;
    assign mem_we      = (win_s == OWN_WR);
    assign mem_addr    = sel_addr_s;
    assign mem_din     = sel_din_s;
    assign err_addr    = err_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign tx_rvalid   = tx_rvalid_q;
    assign tx_rdata    = tx_rdata_q;

    // Next-state for pointer, starvation counters, sticky error and read-return pipeline.
    always_comb begin
        ptr_d      = ptr_q;
        wr_cnt_d   = wr_cnt_q;
        tx_cnt_d   = tx_cnt_q;
        mem_addr_d = sel_addr_s;
        mem_din_d  = sel_din_s;
        err_d      = err_q | (granted_s && !range_ok_s);
        tag_vld_d  = (win_s == OWN_DISP) || (win_s == OWN_TX);
        tag_dest_d = win_s;
        tag_ok_d   = range_ok_s;

        if ((win_s == OWN_WR) || (win_s == OWN_TX)) begin
            ptr_d = ~ptr_q;
        end else begin
            ptr_d = ptr_q;
        end

        if (wr_req && (win_s != OWN_WR)) begin
            wr_cnt_d = (wr_cnt_q == CNT_MAX) ? CNT_MAX : wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wr_cnt_d = {CNT_W{1'b0}};
        end

        if (tx_req && (win_s != OWN_TX)) begin
            tx_cnt_d = (tx_cnt_q == CNT_MAX) ? CNT_MAX : tx_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tx_cnt_d = {CNT_W{1'b0}};
        end

        // mem_dout belongs to the tag captured one cycle earlier; out-of-range reads return zero.
        disp_rvalid_d = tag_vld_q && (tag_dest_q == OWN_DISP);
        tx_rvalid_d   = tag_vld_q && (tag_dest_q == OWN_TX);
        if (disp_rvalid_d) begin
            disp_rdata_d = tag_ok_q ? mem_dout : {DATA_W{1'b0}};
        end else begin
            disp_rdata_d = disp_rdata_q;
        end
        if (tx_rvalid_d) begin
            tx_rdata_d = tag_ok_q ? mem_dout : {DATA_W{1'b0}};
        end else begin
            tx_rdata_d = tx_rdata_q;
        end
    end

    // State registers; synchronous reset also discards in-flight read tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= 1'b0;
            wr_cnt_q      <= {CNT_W{1'b0}};
            tx_cnt_q      <= {CNT_W{1'b0}};
            mem_addr_q    <= {ADDR_W{1'b0}};
            mem_din_q     <= {DATA_W{1'b0}};
            err_q         <= 1'b0;
            tag_vld_q     <= 1'b0;
            tag_dest_q    <= OWN_NONE;
            tag_ok_q      <= 1'b0;
            disp_rvalid_q <= 1'b0;
            tx_rvalid_q   <= 1'b0;
            disp_rdata_q  <= {DATA_W{1'b0}};
            tx_rdata_q    <= {DATA_W{1'b0}};
        end else begin
            ptr_q         <= ptr_d;
            wr_cnt_q      <= wr_cnt_d;
            tx_cnt_q      <= tx_cnt_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            err_q         <= err_d;
            tag_vld_q     <= tag_vld_d;
            tag_dest_q    <= tag_dest_d;
            tag_ok_q      <= tag_ok_d;
            disp_rvalid_q <= disp_rvalid_d;
            tx_rvalid_q   <= tx_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            tx_rdata_q    <= tx_rdata_d;
        end
    end

endmodule
